// File: rtl/hr_pkg.sv
// Shared types and widths for the heart-rate controller.
//   hr_state_t : sequencer state (IDLE, WAIT_TICK, REQ, EVAL)
//   ADC_W      : ADC sample width
//   PERIOD_W   : width of period / sample counters
package hr_pkg;

  localparam int unsigned ADC_W    = 12;
  localparam int unsigned PERIOD_W = 12;

  typedef enum logic [1:0] {
    StIdle,
    StWaitTick,
    StReq,
    StEval
  } hr_state_t;

endpackage

// File: rtl/hr_if.sv
// ADC conversion handshake.
//   adc_req  : conversion request, held until adc_ack
//   adc_ack  : conversion done, adc_data valid in the same cycle
//   adc_data : sample value
// master = controller side, slave = ADC side.
interface hr_if;

  logic                     adc_req;
  logic                     adc_ack;
  logic [hr_pkg::ADC_W-1:0] adc_data;

  modport master (output adc_req, input adc_ack, input adc_data);
  modport slave  (input adc_req, output adc_ack, output adc_data);

endinterface

// File: rtl/pulse_fsm.sv
// Hysteresis comparator: pulse rises when din > THRESH_HI, falls when din <= THRESH_LO,
// otherwise holds.
//   clk, rst : clock, synchronous active-high reset (comparator low)
//   din      : sample under test
//   pulse    : comparator level for the current din (combinational on din and stored level)
module pulse_fsm import hr_pkg::*; #(
  parameter logic [ADC_W-1:0] THRESH_HI = 12'd2100,
  parameter logic [ADC_W-1:0] THRESH_LO = 12'd2000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ADC_W-1:0] din,
  output logic             pulse
);

  logic pulse_q, pulse_d;

  always_comb begin
    pulse_d = pulse_q;
    if (din > THRESH_HI) begin
      pulse_d = 1'b1;
    end else if (din <= THRESH_LO) begin
      pulse_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= pulse_d;
    end
  end

  // Expose the level for the current din so EVAL sees a freshly captured sample at once.
  assign pulse = pulse_d;

endmodule

// File: rtl/heartrate_ctrl.sv
// Heart-rate controller: paces ADC conversions, detects beats with hysteresis and a
// refractory window, measures beat period in samples and flags loss of signal.
//   clk, rst     : clock, synchronous active-high reset
//   enable       : run sampling and detection
//   adc          : ADC handshake (hr_if.master)
//   beat         : one-cycle strobe per accepted beat (cycle after the crossing adc_ack)
//   period       : samples between the last two accepted beats
//   period_valid : period holds a valid measurement
//   avg_period   : mean of last 4 periods with HR_AVG_EN defined, else equal to period
//   no_signal    : no accepted beat within TIMEOUT samples
//   overrun      : sticky, a tick arrived while a conversion was pending
// Build option: define HR_AVG_EN to build the 4-entry period averager.
module heartrate_ctrl import hr_pkg::*; #(
  parameter int unsigned      SAMPLE_DIV = 100000,
  parameter logic [ADC_W-1:0] THRESH_HI  = 12'd2100,
  parameter logic [ADC_W-1:0] THRESH_LO  = 12'd2000,
  parameter int unsigned      REFRACT    = 250,
  parameter int unsigned      TIMEOUT    = 3000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  hr_if.master                adc,
  output logic                beat,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic [PERIOD_W-1:0] avg_period,
  output logic                no_signal,
  output logic                overrun
);

  localparam int unsigned DivW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DivW-1:0]     DivLoad = DivW'(SAMPLE_DIV - 1);
  localparam logic [PERIOD_W-1:0] Refract = PERIOD_W'(REFRACT);
  localparam logic [PERIOD_W-1:0] Timeout = PERIOD_W'(TIMEOUT);

  hr_state_t           state_q, state_d;
  logic [DivW-1:0]     div_q, div_d;
  logic [ADC_W-1:0]    sample_q, sample_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                armed_q, armed_d;
  logic                pulse_last_q, pulse_last_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                pv_q, pv_d;
  logic                nosig_q, nosig_d;
  logic                ovr_q, ovr_d;

  logic                tick;
  logic                pulse;
  logic                cand;
  logic [PERIOD_W-1:0] cnt_inc;

  pulse_fsm #(
    .THRESH_HI (THRESH_HI),
    .THRESH_LO (THRESH_LO)
  ) u_pulse (
    .clk   (clk),
    .rst   (rst),
    .din   (sample_q),
    .pulse (pulse)
  );

  assign tick    = (state_q != StIdle) && (div_q == '0);
  assign cnt_inc = (cnt_q >= Timeout) ? Timeout : cnt_q + 1'b1;
  assign cand    = pulse && !pulse_last_q;

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    sample_d     = sample_q;
    cnt_d        = cnt_q;
    armed_d      = armed_q;
    pulse_last_d = pulse_last_q;
    period_d     = period_q;
    pv_d         = pv_q;
    nosig_d      = nosig_q;
    ovr_d        = ovr_q;
    beat         = 1'b0;

    if (state_q != StIdle) begin
      div_d = tick ? DivLoad : div_q - 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        armed_d = 1'b0;
        cnt_d   = '0;
        if (enable) begin
          state_d = StWaitTick;
          div_d   = DivLoad;
        end
      end
      StWaitTick: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (tick) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (tick) begin
          ovr_d = 1'b1;
        end
        if (adc.adc_ack) begin
          sample_d = adc.adc_data;
          state_d  = StEval;
        end
      end
      StEval: begin
        // A tick landing here is simply skipped; the next one starts a new conversion.
        cnt_d        = cnt_inc;
        pulse_last_d = pulse;
        if (cand && (!armed_q || cnt_inc >= Refract)) begin
          beat    = 1'b1;
          armed_d = 1'b1;
          cnt_d   = '0;
          nosig_d = 1'b0;
          if (armed_q) begin
            period_d = cnt_inc;
            pv_d     = 1'b1;
          end
        end else if (cnt_inc == Timeout) begin
          nosig_d = 1'b1;
          armed_d = 1'b0;
          pv_d    = 1'b0;
        end
        state_d = enable ? StWaitTick : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      div_q        <= '0;
      sample_q     <= '0;
      cnt_q        <= '0;
      armed_q      <= 1'b0;
      pulse_last_q <= 1'b0;
      period_q     <= '0;
      pv_q         <= 1'b0;
      nosig_q      <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      sample_q     <= sample_d;
      cnt_q        <= cnt_d;
      armed_q      <= armed_d;
      pulse_last_q <= pulse_last_d;
      period_q     <= period_d;
      pv_q         <= pv_d;
      nosig_q      <= nosig_d;
      ovr_q        <= ovr_d;
    end
  end

  assign adc.adc_req  = (state_q == StReq);
  assign period       = period_q;
  assign period_valid = pv_q;
  assign no_signal    = nosig_q;
  assign overrun      = ovr_q;

`ifdef HR_AVG_EN
  logic [PERIOD_W-1:0] hist_q [4];
  logic                filled_q;
  logic                hist_push, hist_clr;
  logic [PERIOD_W+1:0] hist_sum;

  // Push exactly when a new period is measured; clear on timeout or while idle.
  assign hist_push = (state_q == StEval) && beat && armed_q;
  assign hist_clr  = (state_q == StIdle) ||
                     ((state_q == StEval) && !beat && (cnt_inc == Timeout));

  always_ff @(posedge clk) begin
    if (rst || hist_clr) begin
      for (int i = 0; i < 4; i++) hist_q[i] <= '0;
      filled_q <= 1'b0;
    end else if (hist_push) begin
      filled_q <= 1'b1;
      if (!filled_q) begin
        for (int i = 0; i < 4; i++) hist_q[i] <= cnt_inc;
      end else begin
        for (int i = 0; i < 3; i++) hist_q[i] <= hist_q[i+1];
        hist_q[3] <= cnt_inc;
      end
    end
  end

  assign hist_sum   = {2'b00, hist_q[0]} + {2'b00, hist_q[1]} +
                      {2'b00, hist_q[2]} + {2'b00, hist_q[3]};
  assign avg_period = hist_sum[PERIOD_W+1:2];
`else
  assign avg_period = period_q;
`endif

endmodule

// File: tb/tb_heartrate_ctrl.sv
module tb_heartrate_ctrl;

  localparam int SDIV = 4;
  localparam int REF  = 5;
  localparam int TMO  = 40;
  localparam int THI  = 2100;
  localparam int TLO  = 2000;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        beat;
  logic [11:0] period;
  logic        period_valid;
  logic [11:0] avg_period;
  logic        no_signal;
  logic        overrun;

  hr_if adc();

  heartrate_ctrl #(
    .SAMPLE_DIV (SDIV),
    .THRESH_HI  (12'd2100),
    .THRESH_LO  (12'd2000),
    .REFRACT    (REF),
    .TIMEOUT    (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .adc          (adc),
    .beat         (beat),
    .period       (period),
    .period_valid (period_valid),
    .avg_period   (avg_period),
    .no_signal    (no_signal),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // Reference model: samples since the last accepted beat, hysteresis level, flags.
  bit level_m, armed_m, pv_m, nosig_m, ov_m;
  int n_since, period_m;
  int hist[$];
  int last_rise;
  bit lb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    level_m = 0; armed_m = 0; pv_m = 0; nosig_m = 0; ov_m = 0;
    n_since = 0; period_m = 0; hist.delete();
  endtask

  task automatic model_idle();
    armed_m = 0; n_since = 0; hist.delete();
  endtask

  task automatic model_sample(input int v, output bit b);
    bit prev;
    prev = level_m;
    if (v > THI) level_m = 1;
    else if (v <= TLO) level_m = 0;
    if (n_since < TMO) n_since++;
    b = 0;
    if (level_m && !prev && (!armed_m || n_since >= REF)) begin
      b = 1;
      if (armed_m) begin
        period_m = n_since;
        pv_m = 1;
        if (hist.size() == 0) hist = '{n_since, n_since, n_since, n_since};
        else begin
          hist.push_back(n_since);
          void'(hist.pop_front());
        end
      end
      armed_m = 1; n_since = 0; nosig_m = 0;
    end else if (n_since >= TMO) begin
      nosig_m = 1; armed_m = 0; pv_m = 0; hist.delete();
    end
  endtask

  function automatic int exp_avg();
`ifdef HR_AVG_EN
    int s = 0;
    foreach (hist[i]) s += hist[i];
    return s / 4;
`else
    return period_m;
`endif
  endfunction

  task automatic wait_req();
    int k = 0;
    while (adc.adc_req !== 1'b1 && k < 50) begin
      @(posedge clk); #1; k++;
    end
    chk("req_wait", adc.adc_req, 1);
    last_rise = cyc;
  endtask

  // One conversion: ack in the lat-th cycle of the request, then check against the model.
  task automatic do_sample(input int v, input int lat, output bit obs_beat);
    bit b;
    wait_req();
    for (int i = 1; i < lat; i++) begin
      @(posedge clk); #1;
    end
    adc.adc_ack = 1'b1; adc.adc_data = 12'(v);
    @(posedge clk); #1;
    adc.adc_ack = 1'b0;
    model_sample(v, b);
    if (lat >= SDIV) ov_m = 1;  // the next tick lands while the request is pending
    obs_beat = beat;
    chk("beat", beat, b);
    @(posedge clk); #1;
    chk("period", period, period_m);
    chk("period_valid", period_valid, pv_m);
    chk("no_signal", no_signal, nosig_m);
    chk("avg_period", avg_period, exp_avg());
    chk("overrun", overrun, ov_m);
  endtask

  task automatic feed(input int v, input int n);
    for (int i = 0; i < n; i++) do_sample(v, 1, lb);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"}, adc.adc_req, 0);
    chk({tag, "_beat"}, beat, 0);
    chk({tag, "_period"}, period, 0);
    chk({tag, "_pv"}, period_valid, 0);
    chk({tag, "_avg"}, avg_period, 0);
    chk({tag, "_nosig"}, no_signal, 0);
    chk({tag, "_ovr"}, overrun, 0);
  endtask

  initial begin
    int c0, r1, hi, saved_period;
    int vals[7] = '{1900, 2000, 2001, 2050, 2100, 2101, 2200};
    bit b;

    rst = 1'b1; enable = 1'b0; adc.adc_ack = 1'b0; adc.adc_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Handshake: first request SDIV+1 cycles after enable, request held 3 cycles.
    enable = 1'b1; c0 = cyc;
    wait_req();
    chk("first_req_latency", last_rise - c0, SDIV + 1);
    @(posedge clk); #1; chk("req_hold1", adc.adc_req, 1);
    @(posedge clk); #1; chk("req_hold2", adc.adc_req, 1);
    adc.adc_ack = 1'b1; adc.adc_data = 12'd1900;
    @(posedge clk); #1;
    adc.adc_ack = 1'b0;
    chk("req_width3", adc.adc_req, 0);
    model_sample(1900, b);
    chk("hs_beat", beat, b);
    @(posedge clk); #1;
    // With prompt acks requests follow every SDIV cycles.
    do_sample(1900, 1, lb);
    r1 = last_rise;
    wait_req();
    chk("req_interval", last_rise - r1, SDIV);
    do_sample(1900, 1, lb);

    // Beats: 9 low + 1 high, twice.
    feed(1900, 9);
    do_sample(2200, 1, lb);
    chk("beat1", lb, 1);
    chk("beat1_pv", period_valid, 0);
    feed(1900, 9);
    do_sample(2200, 1, lb);
    chk("beat2", lb, 1);
    chk("beat2_period", period, 10);
    chk("beat2_pv", period_valid, 1);

    // Hysteresis: 2200, 2050, 2200 gives one beat.
    feed(1900, 5);
    do_sample(2200, 1, lb); chk("hys_beat", lb, 1);
    do_sample(2050, 1, lb); chk("hys_hold", lb, 0);
    do_sample(2200, 1, lb); chk("hys_nobeat", lb, 0);
    // Refractory: crossing 3 samples after a beat is ignored.
    feed(1900, 5);
    do_sample(2200, 1, lb); chk("ref_beat", lb, 1);
    feed(1900, 2);
    do_sample(2200, 1, lb); chk("ref_ignored", lb, 0);

    // Timeout: 40 quiet samples after a beat.
    feed(1900, 5);
    do_sample(2200, 1, lb); chk("to_beat", lb, 1);
    feed(1900, 39);
    chk("to_not_yet", no_signal, 0);
    feed(1900, 1);
    chk("to_nosig", no_signal, 1);
    chk("to_pv", period_valid, 0);
    saved_period = period_m;
    do_sample(2200, 1, lb);
    chk("to_recover_beat", lb, 1);
    chk("to_recover_nosig", no_signal, 0);
    chk("to_period_held", period, saved_period);

    // Periods 10, 10, 14, 14.
    feed(1900, 9);  do_sample(2200, 1, lb);
    feed(1900, 9);  do_sample(2200, 1, lb);
    feed(1900, 13); do_sample(2200, 1, lb);
    feed(1900, 13); do_sample(2200, 1, lb);
    chk("avg_last_period", period, 14);
`ifdef HR_AVG_EN
    chk("avg_value", avg_period, 12);
`else
    chk("avg_value", avg_period, 14);
`endif

    // Disable: no requests while idle; re-enable starts unarmed with period held.
    enable = 1'b0;
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (adc.adc_req === 1'b1) hi++;
    end
    chk("idle_no_req", hi, 0);
    model_idle();
    enable = 1'b1;
    feed(1900, 3);
    do_sample(2200, 1, lb);
    chk("reenable_beat", lb, 1);
    chk("reenable_period", period, 14);

    // Randomised samples with ack latencies that never overlap a tick.
    for (int i = 0; i < 150; i++) begin
      int v;
      int idx;
      idx = $urandom_range(0, 7);
      v = (idx == 7) ? int'($urandom_range(0, 4095)) : vals[idx];
      do_sample(v, $urandom_range(1, 3), lb);
    end
    chk("rand_no_overrun", overrun, 0);

    // Overrun: ack held low 6 cycles.
    do_sample(1900, 7, lb);
    chk("overrun_set", overrun, 1);
    feed(1900, 2);
    chk("overrun_sticky", overrun, 1);

    // Reset in the middle of a request.
    wait_req();
    @(posedge clk); #1;
    chk("mid_req", adc.adc_req, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("mid_rst");
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/heartrate_ctrl.md
HEARTRATE_CTRL -- requirements
Module: heartrate_ctrl

Interface
REQ-001 Parameter SAMPLE_DIV, default 100000; clk cycles between ADC sample ticks.
REQ-002 Parameter THRESH_HI, default 12'd2100; hysteresis upper threshold.
REQ-003 Parameter THRESH_LO, default 12'd2000; hysteresis lower threshold.
REQ-004 Parameter REFRACT, default 250; minimum samples between accepted beats.
REQ-005 Parameter TIMEOUT, default 3000; samples without a beat before no_signal.
REQ-006 Reset rst, synchronous, active-high; clock clk.
REQ-007 Port clk, input, 1, system clock.
REQ-008 Port rst, input, 1, synchronous active-high reset.
REQ-009 Port enable, input, 1, run sampling and detection.
REQ-010 Port adc_req, output, 1, conversion request.
REQ-011 Port adc_ack, input, 1, conversion done; adc_data valid this cycle.
REQ-012 Port adc_data, input, 12, sample value.
REQ-013 Port beat, output, 1, one-cycle strobe per accepted beat.
REQ-014 Port period, output, 12, samples between the last two accepted beats.
REQ-015 Port period_valid, output, 1, period holds a valid measurement.
REQ-016 Port avg_period, output, 12, averaged period; see Configuration.
REQ-017 Port no_signal, output, 1, timeout flag.
REQ-018 Port overrun, output, 1, sticky; a tick arrived while a handshake was pending.

Function
REQ-019 FSM states: IDLE, WAIT_TICK, REQ, EVAL.
REQ-020 IDLE goes to WAIT_TICK when enable=1; the tick counter loads SAMPLE_DIV-1.
REQ-021 The tick counter decrements every cycle outside IDLE and reloads at 0; zero is the tick.
REQ-022 WAIT_TICK goes to REQ on tick.
REQ-023 adc_req is 1 exactly while the FSM is in REQ.
REQ-024 adc_req holds until adc_ack; adc_ack outside REQ is ignored.
REQ-025 On adc_ack in REQ, adc_data is captured into sample_q and the FSM goes to EVAL.
REQ-026 A tick while in REQ sets overrun and is dropped; the counter keeps running.
REQ-027 sample_q drives the hysteresis comparator: pulse rises when sample_q > THRESH_HI and falls when sample_q <= THRESH_LO.
REQ-028 In EVAL, sample_cnt increments, saturating at TIMEOUT.
REQ-029 In EVAL, a 0->1 pulse edge since the previous EVAL is a candidate beat.
REQ-030 A candidate with armed=0 is accepted: beat=1, armed<=1, sample_cnt<=0, period unchanged.
REQ-031 A candidate with armed=1 and sample_cnt>=REFRACT is accepted: beat=1, period<=sample_cnt, period_valid<=1, sample_cnt<=0.
REQ-032 A candidate with armed=1 and sample_cnt<REFRACT is ignored.
REQ-033 When sample_cnt reaches TIMEOUT: no_signal<=1, armed<=0, period_valid<=0.
REQ-034 An accepted beat clears no_signal.
REQ-035 EVAL goes to WAIT_TICK when enable=1, else to IDLE.
REQ-036 enable=0 in WAIT_TICK goes to IDLE immediately.
REQ-037 enable=0 in REQ completes the handshake, passes through EVAL, then goes to IDLE.
REQ-038 Entering IDLE clears armed and sample_cnt; period and period_valid are held.
REQ-039 Beat latency: beat is asserted the cycle after the adc_ack that carries the crossing sample.

Reset
REQ-040 rst is sampled on clk, active-high, and overrides everything, including mid-handshake.
REQ-041 Reset values: FSM=IDLE, adc_req=0, beat=0, period=0, period_valid=0, avg_period=0, no_signal=0, overrun=0, sample_q=0, comparator low, armed=0.

Configuration
REQ-042 HR_AVG_EN defined: avg_period is the mean of the last 4 valid periods (sum>>2); history fills with the first valid period; history clears on timeout or IDLE.
REQ-043 HR_AVG_EN undefined: avg_period equals period; no averaging logic is built.

Structure
REQ-044 Package hr_pkg holds the state enum (hr_state_t) and the constants ADC_W=12 and PERIOD_W=12.
REQ-045 The hysteresis comparator is instantiated as sub-module pulse_fsm, with THRESH_HI and THRESH_LO passed through and din=sample_q.

Verification (bench params: SAMPLE_DIV=4, REFRACT=5, TIMEOUT=40)
REQ-046 Handshake: enable=1, adc_ack 3 cycles after adc_req -> adc_req high exactly 3 cycles; next adc_req 4 cycles after the previous tick.
REQ-047 Beats: samples 1900 x9, 2200 x1, repeated -> first beat gives period_valid=0; second beat gives period=10, period_valid=1.
REQ-048 Hysteresis and refractory: samples 2200,2050,2200 -> one beat only; a crossing 3 samples after a beat -> ignored.
REQ-049 Timeout: constant 1900 for 40 samples after a beat -> no_signal=1, period_valid=0; next crossing -> beat=1, no_signal=0, period unchanged.
REQ-050 Overrun and reset: hold adc_ack low for 6 cycles -> overrun=1; assert rst mid-REQ -> adc_req=0 next cycle and all outputs at reset values.
REQ-051 HR_AVG_EN: periods 10,10,14,14 -> avg_period=12.
